// File: rtl/seq_pkg.sv
// Shared definitions for the pc_sequencer block: state encoding, opcode
// constants and the writeback-classification helper.
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_STORE = 4'b1111;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_LOADI = 4'b0110;
    localparam logic [3:0] OP_CMP   = 4'b1001;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BGE   = 4'b1100;
    localparam logic [3:0] OP_BLE   = 4'b1101;

    // Opcodes that write the register file in WB: ALU ops, moves and loadi.
    // Loads write in their ack cycle instead, so they are excluded here.
    function automatic logic writes_in_wb(input logic [3:0] op);
        return !(op inside {OP_STORE, OP_LOAD, OP_CMP, OP_BEQ, OP_BGE, OP_BLE});
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_STORE) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/branch_eval.sv
// Combinational branch resolution: classifies the opcode as a conditional
// branch and evaluates its condition against the registered ALU flags.
module branch_eval
    import seq_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] op,
    input  logic            zero,
    input  logic            sign,
    input  logic            carry,
    input  logic            overflow,
    output logic            is_branch,
    output logic            taken
);

    logic [3:0] op4;
    // No branch in this ISA tests carry; it is accepted for interface symmetry.
    logic       unused_carry;

    assign op4          = 4'(op);
    assign unused_carry = carry;

    // Decode branch opcodes and evaluate their signed/equal conditions.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        is_branch = 1'b0;
        taken     = 1'b0;
        case (op4)
            OP_BEQ: begin
                is_branch = 1'b1;
                taken     = zero;
            end
            OP_BGE: begin
                is_branch = 1'b1;
                taken     = (sign == overflow);
            end
            OP_BLE: begin
                is_branch = 1'b1;
                taken     = zero || (sign != overflow);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: owns the program counter and walks each
// instruction through FETCH, DECODE, EXEC, optional MEM and WB, issuing
// one-cycle enables to the datapath.
// Optional feature macro: PC_SEQUENCER_PERF_EN adds retired/cycles counters.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W    = 10,
    parameter int              OP_W    = 4,
    parameter logic [PC_W-1:0] PC_LAST = {PC_W{1'b1}}
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [OP_W-1:0] instr_op,
    input  logic [PC_W-1:0] target,
    input  logic            zero,
    input  logic            sign,
    input  logic            carry,
    input  logic            overflow,
    input  logic            mem_ack,
    output logic [PC_W-1:0] pc,
    output logic            ir_load,
    output logic            exec_en,
    output logic            flag_load,
    output logic            reg_we,
    output logic            mem_req,
    output logic            done,
    output logic            busy
`ifdef PC_SEQUENCER_PERF_EN
    ,
    output logic [15:0]     retired,
    output logic [15:0]     cycles
`endif
);

    state_t          state, state_n;
    logic [OP_W-1:0] op_q;
    logic [3:0]      op4;
    logic            taken_q;
    logic [PC_W-1:0] target_q;
    logic            is_branch;
    logic            br_taken;

    assign op4 = 4'(op_q);

    branch_eval #(.OP_W(OP_W)) u_branch_eval (
        .op        (op_q),
        .zero      (zero),
        .sign      (sign),
        .carry     (carry),
        .overflow  (overflow),
        .is_branch (is_branch),
        .taken     (br_taken)
    );

    // State register plus the per-state captures: opcode in DECODE, branch
    // decision and target in EXEC, program counter update in WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pc       <= '0;
            op_q     <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_n;
            case (state)
                IDLE:   if (start) pc <= '0;
                DECODE: op_q <= instr_op;
                EXEC: begin
                    taken_q  <= is_branch && br_taken;
                    target_q <= target;
                end
                WB:     pc <= taken_q ? target_q : pc + PC_W'(1);
                default: ;
            endcase
        end
    end

    // Next-state logic and Moore strobes; reg_we for loads is qualified by mem_ack.
    always_comb begin
        state_n   = state;
        ir_load   = 1'b0;
        exec_en   = 1'b0;
        flag_load = 1'b0;
        reg_we    = 1'b0;
        mem_req   = 1'b0;
        case (state)
            IDLE:   if (start) state_n = FETCH;
            FETCH:  state_n = DECODE;
            DECODE: begin
                ir_load = 1'b1;
                state_n = EXEC;
            end
            EXEC: begin
                exec_en   = 1'b1;
                flag_load = (op4 == OP_CMP);
                state_n   = (!is_branch && is_mem_op(op4)) ? MEM : WB;
            end
            MEM: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    reg_we  = (op4 == OP_LOAD);
                    state_n = WB;
                end
            end
            WB: begin
                reg_we  = writes_in_wb(op4);
                state_n = (pc == PC_LAST) ? HALT : FETCH;
            end
            HALT:   if (!start) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign done = (state == HALT);
    assign busy = (state != IDLE) && (state != HALT);

`ifdef PC_SEQUENCER_PERF_EN
    // Saturating performance counters, cleared when a new run leaves IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
            cycles  <= '0;
        end else if (state == IDLE && start) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            if (state == WB && retired != 16'hFFFF) retired <= retired + 16'd1;
            if (busy && cycles != 16'hFFFF)         cycles  <= cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer. dut_a has PC_LAST=3 for the
// straight-line run-to-halt sequence; dut_b uses the full address range for
// branch, memory and reset scenarios.
module tb_pc_sequencer;
    import seq_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] instr_op;
    logic [9:0] target;
    logic       zero, sign, carry, overflow;
    logic       mem_ack;

    logic [9:0] a_pc, b_pc;
    logic       a_ir_load, a_exec_en, a_flag_load, a_reg_we, a_mem_req, a_done, a_busy;
    logic       b_ir_load, b_exec_en, b_flag_load, b_reg_we, b_mem_req, b_done, b_busy;
`ifdef PC_SEQUENCER_PERF_EN
    logic [15:0] a_retired, a_cycles, b_retired, b_cycles;
`endif

    int checks = 0;
    int errors = 0;

    pc_sequencer #(.PC_W(10), .OP_W(4), .PC_LAST(10'd3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_op(instr_op), .target(target),
        .zero(zero), .sign(sign), .carry(carry), .overflow(overflow), .mem_ack(mem_ack),
        .pc(a_pc), .ir_load(a_ir_load), .exec_en(a_exec_en), .flag_load(a_flag_load),
        .reg_we(a_reg_we), .mem_req(a_mem_req), .done(a_done), .busy(a_busy)
`ifdef PC_SEQUENCER_PERF_EN
        , .retired(a_retired), .cycles(a_cycles)
`endif
    );

    pc_sequencer #(.PC_W(10), .OP_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .instr_op(instr_op), .target(target),
        .zero(zero), .sign(sign), .carry(carry), .overflow(overflow), .mem_ack(mem_ack),
        .pc(b_pc), .ir_load(b_ir_load), .exec_en(b_exec_en), .flag_load(b_flag_load),
        .reg_we(b_reg_we), .mem_req(b_mem_req), .done(b_done), .busy(b_busy)
`ifdef PC_SEQUENCER_PERF_EN
        , .retired(b_retired), .cycles(b_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Runs one non-memory instruction on dut_b, starting in its FETCH cycle and
    // returning in the next FETCH cycle. Opcode, flags and target are scrambled
    // outside their valid cycles to show they are only sampled where intended.
    task automatic run_basic(input logic [3:0] op, input logic [9:0] tgt,
                             input logic z, input logic s, input logic o,
                             output logic fl, output logic we_wb);
        next_cycle();                         // DECODE
        instr_op = op;
        next_cycle();                         // EXEC
        instr_op = 4'b0000;
        target = tgt; zero = z; sign = s; overflow = o;
        #1;
        fl = b_flag_load;
        next_cycle();                         // WB
        target = ~tgt; zero = ~z; sign = ~s; overflow = ~o;
        #1;
        we_wb = b_reg_we;
        next_cycle();                         // next FETCH
    endtask

    initial begin
        logic       fl, we;
        int         we_cnt;
        int         req_cnt;
        logic [9:0] exp_pc;
        logic [9:0] tgt;
        logic [2:0] idx;
        logic       exp_taken;
        logic [7:0] bge_mask;
        logic [7:0] ble_mask;

        // Taken vectors indexed by {zero, sign, overflow}.
        bge_mask = 8'b1001_1001;
        ble_mask = 8'b1111_0110;

        // ---------------- reset state ----------------
        rst_n = 1'b0; start = 1'b0; instr_op = 4'b0111; target = '0;
        zero = 1'b0; sign = 1'b0; carry = 1'b0; overflow = 1'b0; mem_ack = 1'b0;
        #2;
        check("rst_pc",      a_pc, 0);
        check("rst_done",    a_done, 0);
        check("rst_busy",    a_busy, 0);
        check("rst_reg_we",  a_reg_we, 0);
        check("rst_mem_req", a_mem_req, 0);
        check("rst_ir_load", a_ir_load, 0);

        @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b1;
        #1;
        check("idle_busy", a_busy, 0);

        // ---------------- straight-line run to HALT, PC_LAST=3 ----------------
        next_cycle();                         // IDLE -> FETCH edge
        we_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            check("t1_pc",      a_pc, k / 4);
            check("t1_reg_we",  a_reg_we, (k % 4) == 3);
            check("t1_ir_load", a_ir_load, (k % 4) == 1);
            check("t1_exec_en", a_exec_en, (k % 4) == 2);
            check("t1_done",    a_done, 0);
            check("t1_busy",    a_busy, 1);
            if (a_reg_we) we_cnt++;
            next_cycle();
        end
        check("t1_we_count", we_cnt, 4);
        check("t1_halt_done", a_done, 1);
        check("t1_halt_busy", a_busy, 0);
        check("t1_halt_pc",   a_pc, 4);
        next_cycle();                         // start still high: stays in HALT
        check("t1_halt_hold", a_done, 1);
        check("t1_halt_pc_hold", a_pc, 4);
        start = 1'b0;
        next_cycle();                         // HALT -> IDLE
        check("t1_idle_done", a_done, 0);
        check("t1_idle_busy", a_busy, 0);

        // ---------------- branches on dut_b ----------------
        rst_n = 1'b0;
        #1;
        check("rst2_busy", b_busy, 0);
        next_cycle();
        rst_n = 1'b1;
        start = 1'b1;
        next_cycle();                         // FETCH at pc 0
        check("br_start_pc", b_pc, 0);

        run_basic(OP_BEQ, 10'd5, 1'b1, 1'b0, 1'b0, fl, we);
        check("beq_jump_to_5", b_pc, 5);
        run_basic(OP_BEQ, 10'd20, 1'b1, 1'b0, 1'b0, fl, we);
        check("beq_taken_pc", b_pc, 20);
        check("beq_no_we",    we, 0);
        check("beq_no_flag",  fl, 0);
        run_basic(OP_BEQ, 10'd5, 1'b1, 1'b0, 1'b0, fl, we);
        check("beq_back_to_5", b_pc, 5);
        run_basic(OP_BEQ, 10'd20, 1'b0, 1'b0, 1'b0, fl, we);
        check("beq_not_taken_pc", b_pc, 6);

        run_basic(OP_CMP, 10'd40, 1'b1, 1'b1, 1'b1, fl, we);
        check("cmp_flag_load", fl, 1);
        check("cmp_no_we",     we, 0);
        check("cmp_pc",        b_pc, 7);

        run_basic(OP_LOADI, 10'd40, 1'b1, 1'b0, 1'b0, fl, we);
        check("loadi_we",      we, 1);
        check("loadi_no_flag", fl, 0);
        check("loadi_pc",      b_pc, 8);

        // ---------------- BGE / BLE sweep ----------------
        exp_pc = 10'd8;
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            tgt = exp_pc + 10'd2;
            exp_taken = bge_mask[idx];
            run_basic(OP_BGE, tgt, idx[2], idx[1], idx[0], fl, we);
            exp_pc = exp_taken ? tgt : exp_pc + 10'd1;
            check("bge_pc",      b_pc, exp_pc);
            check("bge_no_flag", fl, 0);
            check("bge_no_we",   we, 0);
        end
        for (int i = 0; i < 8; i++) begin
            idx = 3'(i);
            tgt = exp_pc + 10'd2;
            exp_taken = ble_mask[idx];
            run_basic(OP_BLE, tgt, idx[2], idx[1], idx[0], fl, we);
            exp_pc = exp_taken ? tgt : exp_pc + 10'd1;
            check("ble_pc",      b_pc, exp_pc);
            check("ble_no_flag", fl, 0);
            check("ble_no_we",   we, 0);
        end

        // ---------------- load with ack on the third MEM cycle ----------------
        next_cycle();                         // DECODE
        instr_op = OP_LOAD;
        mem_ack = 1'b1;                       // stray ack outside MEM is ignored
        next_cycle();                         // EXEC
        instr_op = 4'b0000;
        mem_ack = 1'b0;
        #1;
        check("ld_exec_en",  b_exec_en, 1);
        check("ld_exec_req", b_mem_req, 0);
        next_cycle();                         // MEM cycle 1
        req_cnt = 0;
        for (int m = 0; m < 3; m++) begin
            mem_ack = (m == 2);
            #1;
            if (b_mem_req) req_cnt++;
            check("ld_mem_req", b_mem_req, 1);
            check("ld_reg_we",  b_reg_we, m == 2);
            next_cycle();
        end
        mem_ack = 1'b0;
        #1;
        check("ld_wb_req", b_mem_req, 0);
        check("ld_wb_we",  b_reg_we, 0);
        next_cycle();                         // FETCH
        check("ld_req_count", req_cnt, 3);
        check("ld_pc",        b_pc, exp_pc + 10'd1);
        check("ld_fetch_req", b_mem_req, 0);

        // ---------------- store with immediate ack ----------------
        next_cycle();                         // DECODE
        instr_op = OP_STORE;
        next_cycle();                         // EXEC
        instr_op = 4'b0000;
        next_cycle();                         // MEM cycle 1
        mem_ack = 1'b1;
        #1;
        check("st_mem_req", b_mem_req, 1);
        check("st_reg_we",  b_reg_we, 0);
        next_cycle();                         // WB
        mem_ack = 1'b0;
        #1;
        check("st_wb_req", b_mem_req, 0);
        check("st_wb_we",  b_reg_we, 0);
        next_cycle();                         // FETCH
        check("st_pc",        b_pc, exp_pc + 10'd2);
        check("st_fetch_req", b_mem_req, 0);

        // ---------------- reset during MEM ----------------
        next_cycle();                         // DECODE
        instr_op = OP_LOAD;
        next_cycle();                         // EXEC
        instr_op = 4'b0000;
        next_cycle();                         // MEM, no ack
        #1;
        check("rm_pre_req", b_mem_req, 1);
        rst_n = 1'b0;
        #1;
        check("rm_req", b_mem_req, 0);
        check("rm_busy", b_busy, 0);
        check("rm_pc",   b_pc, 0);
        start = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        check("rm_idle_busy", b_busy, 0);
        check("rm_idle_done", b_done, 0);
        start = 1'b1;
        next_cycle();                         // IDLE -> FETCH
        check("rm_restart_busy", b_busy, 1);
        check("rm_restart_pc",   b_pc, 0);
        run_basic(4'b0111, 10'd40, 1'b0, 1'b0, 1'b0, fl, we);
        check("rm_alu_we", we, 1);
        check("rm_alu_pc", b_pc, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
